branch_predictor_tournament_ras: RTL and testbench

BRANCH_PREDICTOR_TOURNAMENT_RAS -- requirements
Module: branch_predictor_tournament_ras

---
 rtl/branch_predictor_tournament_ras.sv | 194 +++++++++++++++++++
 tb/tb_branch_predictor_tournament_ras.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_tournament_ras.sv
// Tournament direction predictor (bimodal PHT1 vs gshare PHT2, chosen per index by a selector),
// tagged BTB for targets and a circular return address stack. All state moves on the falling edge.
module branch_predictor_tournament_ras #(
    parameter int XLEN      = 64,
    parameter int N         = 10,
    parameter int H         = 10,
    parameter int RAS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic [XLEN-1:0] PCPrediction,
    output logic            predTaken,
    input  logic            we,
    input  logic [XLEN-1:0] PCUpdate,
    input  logic [XLEN-1:0] targetUpdate,
    input  logic            takenUpdate,
    input  logic            isBranch,
    input  logic            isCall,
    input  logic            isReturn,
    output logic            rasEmpty,
    output logic            rasFull
);

    localparam int ENTRIES = 1 << N;
    localparam int TAG_W   = XLEN - N - 2;
    localparam int PTR_W   = $clog2(RAS_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    typedef enum logic [1:0] {
        BT_BRANCH = 2'b00,
        BT_JUMP   = 2'b01,
        BT_CALL   = 2'b10,
        BT_RETURN = 2'b11
    } btb_type_e;

    logic [H-1:0]       ghr_q, ghr_d;
    logic [1:0]         sel_q  [ENTRIES];
    logic [1:0]         pht1_q [ENTRIES];
    logic [1:0]         pht2_q [ENTRIES];
    logic [ENTRIES-1:0] btb_valid_q;
    logic [TAG_W-1:0]   btb_tag_q    [ENTRIES];
    btb_type_e          btb_type_q   [ENTRIES];
    logic [XLEN-1:0]    btb_target_q [ENTRIES];
    logic [XLEN-1:0]    ras_q        [RAS_DEPTH];
    logic [PTR_W-1:0]   ras_ptr_q, ras_ptr_d;
    logic [CNT_W-1:0]   ras_cnt_q, ras_cnt_d;
    logic               ras_empty_q, ras_empty_d;
    logic               ras_full_q, ras_full_d;

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'd1;
        else    return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // ---------------- prediction (purely combinational) ----------------
    logic [N-1:0]     pred_idx;
    logic [TAG_W-1:0] pred_tag;
    logic [N-1:0]     ghr_n;
    logic [PTR_W-1:0] ras_top_idx;
    logic             btb_hit, dir_taken, redirect;
    logic [XLEN-1:0]  pred_target;

    assign pred_idx    = PC[N+1:2];
    assign pred_tag    = PC[XLEN-1:N+2];
    assign ghr_n       = N'(ghr_q);
    assign ras_top_idx = ras_ptr_q - PTR_W'(1);
    assign PCPlus4     = PC + XLEN'(4);

    // NOTE: every signal driven in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        btb_hit     = btb_valid_q[pred_idx] && (btb_tag_q[pred_idx] == pred_tag);
        dir_taken   = sel_q[pred_idx][1] ? pht1_q[pred_idx][1] : pht2_q[pred_idx ^ ghr_n][1];
        redirect    = 1'b0;
        pred_target = btb_target_q[pred_idx];
        if (btb_hit) begin
            case (btb_type_q[pred_idx])
                BT_RETURN: begin
                    redirect = 1'b1;
                    if (!ras_empty_q) pred_target = ras_q[ras_top_idx];
                end
                BT_JUMP, BT_CALL: redirect = 1'b1;
                BT_BRANCH:        redirect = dir_taken;
            endcase
        end
    end

    assign predTaken    = redirect;
    assign PCPrediction = redirect ? pred_target : PCPlus4;
    assign rasEmpty     = ras_empty_q;
    assign rasFull      = ras_full_q;

    // ---------------- update path ----------------
    logic [N-1:0]     upd_idx, upd_idx_g;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_en, br_upd, btb_we, ras_we;
    logic [H:0]       ghr_shift;
    logic [1:0]       pht1_wr_d, pht2_wr_d, sel_wr_d;
    btb_type_e        btb_type_d;
    logic [PTR_W-1:0] ras_wr_idx;
    logic [XLEN-1:0]  ras_wr_d;
    logic             p1_ok, p2_ok;

    assign upd_idx   = PCUpdate[N+1:2];
    assign upd_tag   = PCUpdate[XLEN-1:N+2];
    assign upd_idx_g = upd_idx ^ ghr_n;
    assign upd_en    = we && !reset;
    assign br_upd    = upd_en && isBranch;
    assign btb_we    = upd_en && takenUpdate;
    assign ghr_shift = {ghr_q, takenUpdate};
    assign ras_wr_d  = PCUpdate + XLEN'(4);

    always_comb begin
        // Correctness is judged against the pre-shift history that indexed PHT2.
        p1_ok     = (pht1_q[upd_idx][1] == takenUpdate);
        p2_ok     = (pht2_q[upd_idx_g][1] == takenUpdate);
        pht1_wr_d = sat_step(pht1_q[upd_idx], takenUpdate);
        pht2_wr_d = sat_step(pht2_q[upd_idx_g], takenUpdate);
        sel_wr_d  = sel_q[upd_idx];
        if (p1_ok && !p2_ok)      sel_wr_d = sat_step(sel_q[upd_idx], 1'b1);
        else if (p2_ok && !p1_ok) sel_wr_d = sat_step(sel_q[upd_idx], 1'b0);
        ghr_d = br_upd ? ghr_shift[H-1:0] : ghr_q;

        if (isBranch)      btb_type_d = BT_BRANCH;
        else if (isReturn) btb_type_d = BT_RETURN;
        else if (isCall)   btb_type_d = BT_CALL;
        else               btb_type_d = BT_JUMP;

        ras_we     = 1'b0;
        ras_wr_idx = ras_ptr_q;
        ras_ptr_d  = ras_ptr_q;
        ras_cnt_d  = ras_cnt_q;
        if (upd_en) begin
            if (isCall && isReturn && !ras_empty_q) begin
                ras_we     = 1'b1;
                ras_wr_idx = ras_top_idx;
            end else if (isCall) begin
                // A full stack overwrites its oldest slot, which is exactly where ras_ptr_q points.
                ras_we    = 1'b1;
                ras_ptr_d = ras_ptr_q + PTR_W'(1);
                ras_cnt_d = ras_full_q ? ras_cnt_q : ras_cnt_q + CNT_W'(1);
            end else if (isReturn && !ras_empty_q) begin
                ras_ptr_d = ras_top_idx;
                ras_cnt_d = ras_cnt_q - CNT_W'(1);
            end
        end
        ras_empty_d = (ras_cnt_d == '0);
        ras_full_d  = (ras_cnt_d == CNT_W'(RAS_DEPTH));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
    always_ff @(negedge clk) begin
        if (reset) begin
            ghr_q       <= '0;
            btb_valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                sel_q[i]  <= 2'b10;
                pht1_q[i] <= 2'b10;
                pht2_q[i] <= 2'b10;
            end
            ras_ptr_q   <= '0;
            ras_cnt_q   <= '0;
            ras_empty_q <= 1'b1;
            ras_full_q  <= 1'b0;
        end else begin
            ghr_q       <= ghr_d;
            ras_ptr_q   <= ras_ptr_d;
            ras_cnt_q   <= ras_cnt_d;
            ras_empty_q <= ras_empty_d;
            ras_full_q  <= ras_full_d;
            if (br_upd) begin
                pht1_q[upd_idx]   <= pht1_wr_d;
                pht2_q[upd_idx_g] <= pht2_wr_d;
                sel_q[upd_idx]    <= sel_wr_d;
            end
            if (btb_we) btb_valid_q[upd_idx] <= 1'b1;
        end
    end

    // NOTE: payload arrays are not reset; the BTB valid bits and the RAS count gate every read of them.
    always_ff @(negedge clk) begin
        if (btb_we) begin
            btb_tag_q[upd_idx]    <= upd_tag;
            btb_type_q[upd_idx]   <= btb_type_d;
            btb_target_q[upd_idx] <= targetUpdate;
        end
        if (ras_we && !reset) ras_q[ras_wr_idx] <= ras_wr_d;
    end

    logic unused_bits;
    assign unused_bits = ^{PC[1:0], PCUpdate[1:0], ghr_shift[H]};

endmodule

// File: tb/tb_branch_predictor_tournament_ras.sv
// Directed bench for branch_predictor_tournament_ras: expectations are queued when a probe is
// driven and popped/compared on the rising edge, away from the falling update edge.
module tb_branch_predictor_tournament_ras;

    localparam int XLEN      = 64;
    localparam int N         = 10;
    localparam int H         = 10;
    localparam int RAS_DEPTH = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] PC, PCPlus4, PCPrediction, PCUpdate, targetUpdate;
    logic            predTaken, we, takenUpdate, isBranch, isCall, isReturn, rasEmpty, rasFull;

    branch_predictor_tournament_ras #(
        .XLEN(XLEN), .N(N), .H(H), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .PC(PC), .PCPlus4(PCPlus4), .PCPrediction(PCPrediction),
        .predTaken(predTaken), .we(we), .PCUpdate(PCUpdate), .targetUpdate(targetUpdate),
        .takenUpdate(takenUpdate), .isBranch(isBranch), .isCall(isCall), .isReturn(isReturn),
        .rasEmpty(rasEmpty), .rasFull(rasFull)
    );

    always #5 clk = ~clk;

    typedef enum {SIG_PRED, SIG_PLUS4, SIG_TAKEN, SIG_EMPTY, SIG_FULL} sig_e;
    typedef struct {
        string           tag;
        sig_e            sig;
        logic [XLEN-1:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push_exp(input string tag, input sig_e sig, input logic [XLEN-1:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t            e;
        logic [XLEN-1:0] obs;
        @(posedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sig)
                SIG_PRED:  obs = PCPrediction;
                SIG_PLUS4: obs = PCPlus4;
                SIG_TAKEN: obs = XLEN'(predTaken);
                SIG_EMPTY: obs = XLEN'(rasEmpty);
                default:   obs = XLEN'(rasFull);
            endcase
            total++;
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic expect_pc(input string tag, input logic [XLEN-1:0] pc,
                             input logic [XLEN-1:0] exp_pc, input logic exp_tk);
        @(negedge clk);
        #1;
        PC = pc;
        push_exp({tag, "_plus4"}, SIG_PLUS4, pc + 64'd4);
        push_exp({tag, "_pred"},  SIG_PRED,  exp_pc);
        push_exp({tag, "_taken"}, SIG_TAKEN, XLEN'(exp_tk));
        drain();
    endtask

    task automatic expect_ras(input string tag, input logic exp_empty, input logic exp_full);
        @(negedge clk);
        #1;
        push_exp({tag, "_empty"}, SIG_EMPTY, XLEN'(exp_empty));
        push_exp({tag, "_full"},  SIG_FULL,  XLEN'(exp_full));
        drain();
    endtask

    task automatic update(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt, input logic tk,
                          input logic br, input logic call, input logic ret);
        @(negedge clk);
        #1;
        we = 1'b1; PCUpdate = pc; targetUpdate = tgt; takenUpdate = tk;
        isBranch = br; isCall = call; isReturn = ret;
        @(negedge clk);
        #1;
        we = 1'b0; isBranch = 1'b0; isCall = 1'b0; isReturn = 1'b0; takenUpdate = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; PC = '0; we = 1'b0; PCUpdate = '0; targetUpdate = '0;
        takenUpdate = 1'b0; isBranch = 1'b0; isCall = 1'b0; isReturn = 1'b0;
        do_reset();

        // Reset state.
        expect_pc("rst", 64'h1000, 64'h1004, 1'b0);
        expect_ras("rst_ras", 1'b1, 1'b0);

        // One taken branch update; a same-index different-tag PC must miss.
        update(64'h1000, 64'h2000, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_pc("br_taken", 64'h1000, 64'h2000, 1'b1);
        expect_pc("tag_miss", 64'h2000, 64'h2004, 1'b0);

        // Return entry installed on an empty stack, then a call, then RAS top vs BTB fallback.
        update(64'h5010, 64'h9999, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_ras("pop_empty", 1'b1, 1'b0);
        update(64'h3000, 64'h5000, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_pc("call_tgt", 64'h3000, 64'h5000, 1'b1);
        expect_pc("ret_ras", 64'h5010, 64'h3004, 1'b1);
        expect_ras("one_call", 1'b0, 1'b0);
        update(64'h5010, 64'h9999, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_pc("ret_fallback", 64'h5010, 64'h9999, 1'b1);
        expect_ras("after_pop", 1'b1, 1'b0);

        // Overfill the stack, then drain it in LIFO order.
        do_reset();
        update(64'h7000, 64'hDEAD0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= RAS_DEPTH + 2; i++)
            update(64'(i) * 64'h100, 64'h20000, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_ras("ras_full", 1'b0, 1'b1);
        for (int j = 0; j < RAS_DEPTH; j++) begin
            expect_pc($sformatf("lifo%0d", j), 64'h7000,
                      64'(RAS_DEPTH + 2 - j) * 64'h100 + 64'd4, 1'b1);
            update(64'h7000, 64'hDEAD0, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        expect_ras("ras_drained", 1'b1, 1'b0);
        expect_pc("drained_fb", 64'h7000, 64'hDEAD0, 1'b1);
        update(64'h7000, 64'hDEAD0, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_ras("extra_pop", 1'b1, 1'b0);
        expect_pc("extra_pop_fb", 64'h7000, 64'hDEAD0, 1'b1);

        // Alternating branch: selector drifts to gshare, which predicts the pattern perfectly.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            logic tk;
            tk = (k % 2 == 0);
            if (k >= 30)
                expect_pc($sformatf("gshare%0d", k), 64'h4000, tk ? 64'h4800 : 64'h4004, tk);
            update(64'h4000, 64'h4800, tk, 1'b1, 1'b0, 1'b0);
        end
        expect_pc("gshare40", 64'h4000, 64'h4800, 1'b1);

        // Non-branch jump leaves history alone.
        update(64'h6100, 64'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_pc("jal_tgt", 64'h6100, 64'h8000, 1'b1);
        expect_pc("ghr_kept", 64'h4000, 64'h4800, 1'b1);
        expect_pc("ghr_kept_n", 64'h4000, 64'h4800, 1'b1);

        // Call+return replaces the top with one entry; on an empty stack it pushes.
        update(64'h100, 64'h20000, 1'b1, 1'b0, 1'b1, 1'b0);
        update(64'h6200, 64'h7777, 1'b1, 1'b0, 1'b1, 1'b1);
        expect_pc("callret_top", 64'h6200, 64'h6204, 1'b1);
        expect_ras("callret_cnt", 1'b0, 1'b0);
        update(64'h6200, 64'h7777, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_ras("callret_one", 1'b1, 1'b0);
        expect_pc("callret_fb", 64'h6200, 64'h7777, 1'b1);
        update(64'h6200, 64'h7777, 1'b1, 1'b0, 1'b1, 1'b1);
        expect_ras("callret_push", 1'b0, 1'b0);
        expect_pc("callret_push_top", 64'h6200, 64'h6204, 1'b1);

        // Reset mid-sequence, with a call update held active, wipes everything.
        @(negedge clk);
        #1;
        reset = 1'b1; we = 1'b1; isCall = 1'b1; takenUpdate = 1'b1;
        PCUpdate = 64'h900; targetUpdate = 64'h1234;
        @(negedge clk);
        #1;
        reset = 1'b0; we = 1'b0; isCall = 1'b0; takenUpdate = 1'b0;
        expect_ras("rst_mid", 1'b1, 1'b0);
        expect_pc("rst_mid_btb", 64'h6200, 64'h6204, 1'b0);
        expect_pc("rst_mid_br", 64'h4000, 64'h4004, 1'b0);
        expect_pc("rst_mid_call", 64'h900, 64'h904, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
